survivor_mmu: RTL and testbench

- Parametrised single-clock survivor-memory manager for the Viterbi decoder.
- Accepts N_ACS-bit survivor beats from the ACS array, one segment per beat, and packs them into WD_RAM_DATA-bit words.
- Writes completed words into a circular set of DEPTH trellis pages held in an external single-port synchronous RAM.
- Arbitrates traceback read requests against those writes, with fixed latency and error flags for protocol violations.

---
 rtl/survivor_mmu_pkg.sv | 22 ++
 rtl/survivor_packer.sv | 69 ++++++
 rtl/survivor_mmu.sv | 155 +++++++++++++++
 tb/tb_survivor_mmu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/survivor_mmu_pkg.sv
// Shared helpers for the survivor-memory manager: constant log2 and width
// clamping used to size the segment, word and page fields.
package survivor_mmu_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A field never collapses below one bit, even when it has only one value.
    function automatic int width_of(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

endpackage

// File: rtl/survivor_packer.sv
// Tracks the expected segment and packs in-order survivor beats into RAM words;
// flags the beat that completes a word and where that word belongs in its page.
module survivor_packer
    import survivor_mmu_pkg::*;
#(
    parameter int N_STATES    = 64,
    parameter int N_ACS       = 4,
    parameter int WD_RAM_DATA = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        beat_i,
    input  logic [width_of(N_STATES/N_ACS)-1:0]         seg_i,
    input  logic [N_ACS-1:0]                            surv_i,
    output logic                                        word_completing_o,
    output logic [width_of(N_STATES/WD_RAM_DATA)-1:0]   word_index_o,
    output logic                                        stage_last_o,
    output logic [WD_RAM_DATA-1:0]                      word_o,
    output logic                                        order_err_o
);
    localparam int SEGS   = N_STATES / N_ACS;
    localparam int SPW    = WD_RAM_DATA / N_ACS;
    localparam int SEG_W  = width_of(SEGS);
    localparam int WORD_W = width_of(N_STATES / WD_RAM_DATA);

    logic [SEG_W-1:0]       exp_seg_q, exp_seg_d;
    logic [WD_RAM_DATA-1:0] pack_q, pack_d;
    logic [WD_RAM_DATA-1:0] merged;
    logic [31:0]            slot;
    logic                   in_order;

    assign in_order = beat_i && (seg_i == exp_seg_q);
    assign slot     = 32'(seg_i) % 32'(SPW);

    // The incoming beat overlays its slot so the completing word is available
    // in the same cycle as its last beat.
    for (genvar gi = 0; gi < SPW; gi++) begin : g_slot
        assign merged[gi*N_ACS +: N_ACS] = (in_order && slot == 32'(gi))
                                           ? surv_i : pack_q[gi*N_ACS +: N_ACS];
    end

    assign word_completing_o = in_order && (slot == 32'(SPW - 1));
    assign word_index_o      = WORD_W'(32'(seg_i) / 32'(SPW));
    assign stage_last_o      = (seg_i == SEG_W'(SEGS - 1));
    assign word_o            = merged;
    assign order_err_o       = beat_i && !in_order;

    always_comb begin
        exp_seg_d = exp_seg_q;
        pack_d    = merged;
        if (in_order) begin
            exp_seg_d = (exp_seg_q == SEG_W'(SEGS - 1)) ? '0 : exp_seg_q + SEG_W'(1);
        end
        if (word_completing_o) begin
            pack_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_seg_q <= '0;
            pack_q    <= '0;
        end else begin
            exp_seg_q <= exp_seg_d;
            pack_q    <= pack_d;
        end
    end

endmodule

// File: rtl/survivor_mmu.sv
// Survivor-memory manager: writes packed survivor words into a ring of trellis
// pages and arbitrates traceback reads into the same single-port RAM.
module survivor_mmu
    import survivor_mmu_pkg::*;
#(
    parameter int N_STATES       = 64,
    parameter int N_ACS          = 4,
    parameter int WD_RAM_DATA    = 16,
    parameter int DEPTH          = 8,
    parameter int WD_RAM_ADDRESS = 5
) (
    input  logic                                        CLOCK,
    input  logic                                        Reset,
    input  logic                                        Active,
    input  logic                                        Hold,
    input  logic                                        acs_valid,
    output logic                                        acs_ready,
    input  logic [width_of(N_STATES/N_ACS)-1:0]         acs_seg,
    input  logic [N_ACS-1:0]                            acs_surv,
    output logic [width_of(DEPTH)-1:0]                  wr_page,
    output logic                                        stage_done,
    input  logic                                        tb_req,
    output logic                                        tb_gnt,
    input  logic [width_of(DEPTH)-1:0]                  tb_page,
    input  logic [width_of(N_STATES/WD_RAM_DATA)-1:0]   tb_word,
    output logic                                        tb_valid,
    output logic [WD_RAM_DATA-1:0]                      tb_data,
    output logic                                        ram_en,
    output logic                                        ram_we,
    output logic [WD_RAM_ADDRESS-1:0]                   ram_addr,
    output logic [WD_RAM_DATA-1:0]                      ram_wdata,
    input  logic [WD_RAM_DATA-1:0]                      ram_rdata,
    output logic                                        err_order,
    output logic                                        err_rd_collision
);
    localparam int WPS    = N_STATES / WD_RAM_DATA;
    localparam int WORD_W = width_of(WPS);
    localparam int PAGE_W = width_of(DEPTH);

    if (N_STATES % N_ACS != 0) begin : g_bad_acs
        $error("N_STATES must be a multiple of N_ACS");
    end
    if (WD_RAM_DATA % N_ACS != 0) begin : g_bad_word
        $error("WD_RAM_DATA must be a multiple of N_ACS");
    end
    if (N_STATES % WD_RAM_DATA != 0) begin : g_bad_states
        $error("WD_RAM_DATA must divide N_STATES");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be at least 2");
    end
    if (WD_RAM_ADDRESS < clog2(DEPTH * WPS)) begin : g_bad_addr
        $error("WD_RAM_ADDRESS too narrow for DEPTH*WPS words");
    end

    logic                      accept;
    logic                      word_completing;
    logic [WORD_W-1:0]         word_index;
    logic                      stage_last;
    logic [WD_RAM_DATA-1:0]    pk_word;
    logic                      pk_order_err;
    logic [WD_RAM_ADDRESS-1:0] wr_addr, rd_addr;

    logic [PAGE_W-1:0]         wr_page_q;
    logic                      stage_done_q, rd_pend_q, tb_valid_q;
    logic [WD_RAM_DATA-1:0]    tb_data_q, ram_wdata_q;
    logic                      ram_en_q, ram_we_q;
    logic [WD_RAM_ADDRESS-1:0] ram_addr_q;
    logic                      err_order_q, err_coll_q;

    assign acs_ready = Reset & Active & ~Hold;
    assign accept    = acs_valid & acs_ready;
    // Writes always take the RAM slot; a blocked read simply retries.
    assign tb_gnt    = Reset & ~Hold & tb_req & ~word_completing;

    survivor_packer #(
        .N_STATES    (N_STATES),
        .N_ACS       (N_ACS),
        .WD_RAM_DATA (WD_RAM_DATA)
    ) u_packer (
        .clk               (CLOCK),
        .rst_n             (Reset),
        .beat_i            (accept),
        .seg_i             (acs_seg),
        .surv_i            (acs_surv),
        .word_completing_o (word_completing),
        .word_index_o      (word_index),
        .stage_last_o      (stage_last),
        .word_o            (pk_word),
        .order_err_o       (pk_order_err)
    );

    assign wr_addr = WD_RAM_ADDRESS'(32'(wr_page_q) * 32'(WPS) + 32'(word_index));
    assign rd_addr = WD_RAM_ADDRESS'(32'(tb_page) * 32'(WPS) + 32'(tb_word));

    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            wr_page_q    <= '0;
            stage_done_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            tb_valid_q   <= 1'b0;
            tb_data_q    <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            err_order_q  <= 1'b0;
            err_coll_q   <= 1'b0;
        end else begin
            stage_done_q <= 1'b0;
            // Read pipeline: command -> RAM access -> capture of ram_rdata.
            rd_pend_q    <= ram_en_q & ~ram_we_q;
            tb_valid_q   <= rd_pend_q;
            if (rd_pend_q) begin
                tb_data_q <= ram_rdata;
            end
            if (pk_order_err) begin
                err_order_q <= 1'b1;
            end
            if (word_completing) begin
                ram_en_q    <= 1'b1;
                ram_we_q    <= 1'b1;
                ram_addr_q  <= wr_addr;
                ram_wdata_q <= pk_word;
                if (stage_last) begin
                    stage_done_q <= 1'b1;
                    wr_page_q    <= (wr_page_q == PAGE_W'(DEPTH - 1)) ? '0
                                                                      : wr_page_q + PAGE_W'(1);
                end
            end else if (tb_gnt) begin
                ram_en_q   <= 1'b1;
                ram_we_q   <= 1'b0;
                ram_addr_q <= rd_addr;
                if (tb_page == wr_page_q) begin
                    err_coll_q <= 1'b1;
                end
            end else begin
                ram_en_q <= 1'b0;
                ram_we_q <= 1'b0;
            end
        end
    end

    assign wr_page          = wr_page_q;
    assign stage_done       = stage_done_q;
    assign tb_valid         = tb_valid_q;
    assign tb_data          = tb_data_q;
    assign ram_en           = ram_en_q;
    assign ram_we           = ram_we_q;
    assign ram_addr         = ram_addr_q;
    assign ram_wdata        = ram_wdata_q;
    assign err_order        = err_order_q;
    assign err_rd_collision = err_coll_q;

endmodule

// File: tb/tb_survivor_mmu.sv
// Bench for survivor_mmu: directed vector table, hand sequences for reset/hold
// corners, then random traffic against a behavioural model with a RAM behind it.
module tb_survivor_mmu;

    logic        clk = 1'b0;
    logic        rst_n, active, hold, acs_valid, acs_ready, stage_done;
    logic [3:0]  acs_seg, acs_surv;
    logic [2:0]  wr_page, tb_page;
    logic        tb_req, tb_gnt, tb_valid;
    logic [1:0]  tb_word;
    logic [15:0] tb_data, ram_wdata, ram_rdata;
    logic        ram_en, ram_we, err_order, err_rd_collision;
    logic [4:0]  ram_addr;
    logic [15:0] ram [32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    survivor_mmu dut (
        .CLOCK(clk), .Reset(rst_n), .Active(active), .Hold(hold),
        .acs_valid(acs_valid), .acs_ready(acs_ready), .acs_seg(acs_seg), .acs_surv(acs_surv),
        .wr_page(wr_page), .stage_done(stage_done),
        .tb_req(tb_req), .tb_gnt(tb_gnt), .tb_page(tb_page), .tb_word(tb_word),
        .tb_valid(tb_valid), .tb_data(tb_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .err_order(err_order), .err_rd_collision(err_rd_collision)
    );

    // External single-port synchronous RAM
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram[ram_addr];
        end
    end

    // Behavioural model state
    int m_exp, m_page, m_addr, m_wdata, m_rd_data, m_tbd, wcount;
    int m_word [4];
    int m_mem [32];
    bit m_en, m_we, m_sd, m_rd1, m_tbv, m_erro, m_errc;
    logic seen_ready, seen_gnt;

    typedef struct {
        bit a; bit v; int seg; int surv; bit q; int tp; int tw;
        bit e_gnt; bit e_en; bit e_we; int e_addr; int e_wdata; bit e_erro; bit e_tbv; int e_tbd;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic int packed_word();
        int w = 0;
        for (int k = 0; k < 4; k++) w = w | ((m_word[k] & 15) << (4 * k));
        return w;
    endfunction

    task automatic step(input bit r, input bit a, input bit h, input bit v, input int sg,
                        input int sv, input bit q, input int tp, input int tw);
        bit rdy, acc, inord, compl, gnt, do_rd;
        int rd_tmp;
        @(negedge clk);
        rst_n = r; active = a; hold = h; acs_valid = v;
        acs_seg = 4'(sg); acs_surv = 4'(sv); tb_req = q; tb_page = 3'(tp); tb_word = 2'(tw);
        #1;
        rdy   = r && a && !h;
        acc   = v && rdy;
        inord = acc && (sg == m_exp);
        compl = inord && (sg % 4 == 3);
        gnt   = r && !h && q && !compl;
        seen_ready = acs_ready;
        seen_gnt   = tb_gnt;
        chk("acs_ready", acs_ready, 32'(rdy));
        chk("tb_gnt", tb_gnt, 32'(gnt));
        // RAM acts on whatever command is presented, reset or not
        do_rd  = m_en && !m_we;
        rd_tmp = do_rd ? m_mem[m_addr] : 0;
        if (m_en && m_we) m_mem[m_addr] = m_wdata;
        if (!r) begin
            m_exp = 0; m_page = 0; m_addr = 0; m_wdata = 0; m_tbd = 0; wcount = 0;
            m_en = 0; m_we = 0; m_sd = 0; m_rd1 = 0; m_tbv = 0; m_erro = 0; m_errc = 0;
            for (int k = 0; k < 4; k++) m_word[k] = 0;
        end else begin
            m_tbv = m_rd1;
            if (m_rd1) m_tbd = m_rd_data;
            m_rd1 = do_rd;
            if (do_rd) m_rd_data = rd_tmp;
            m_sd = 0;
            if (acc && !inord) m_erro = 1;
            if (inord) begin
                m_word[sg % 4] = sv;
                m_exp = (m_exp + 1) % 16;
            end
            if (compl) begin
                m_en = 1; m_we = 1; m_addr = m_page * 4 + sg / 4; m_wdata = packed_word();
                if (sg == 15) begin
                    m_sd = 1;
                    m_page = (m_page + 1) % 8;
                end
            end else if (gnt) begin
                m_en = 1; m_we = 0; m_addr = tp * 4 + tw;
                if (tp == m_page) m_errc = 1;
            end else begin
                m_en = 0; m_we = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("ram_en", ram_en, 32'(m_en));
        if (m_en) chk("ram_we", ram_we, 32'(m_we));
        chk("ram_addr", ram_addr, 32'(m_addr));
        chk("ram_wdata", ram_wdata, 32'(m_wdata));
        chk("stage_done", stage_done, 32'(m_sd));
        chk("wr_page", wr_page, 32'(m_page));
        chk("tb_valid", tb_valid, 32'(m_tbv));
        chk("tb_data", tb_data, 32'(m_tbd));
        chk("err_order", err_order, 32'(m_erro));
        chk("err_rd_collision", err_rd_collision, 32'(m_errc));
        // Writes since reset walk the page ring one address at a time
        if (ram_en === 1'b1 && ram_we === 1'b1) begin
            chk("wr_seq_addr", ram_addr, 32'(wcount % 32));
            chk("wr_seq_stage_done", stage_done, 32'(wcount % 4 == 3));
            wcount++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pre2;
        rst_n = 0; active = 0; hold = 0; acs_valid = 0; acs_seg = 0; acs_surv = 0;
        tb_req = 0; tb_page = 0; tb_word = 0;
        m_rd_data = 0;
        for (int k = 0; k < 32; k++) m_mem[k] = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 1, 0, 0);
        pre2 = int'($urandom_range(0, 65535));
        for (int k = 0; k < 32; k++) begin
            ram[k]   = (k == 2) ? 16'(pre2) : 16'h0;
            m_mem[k] = (k == 2) ? pre2 : 0;
        end

        //          a v seg surv q tp tw | gnt en we addr wdata   erro tbv tbd
        vecs[0] = '{1,1, 0, 'hA, 0,0,0,   0,  0, 0, 0,  'h0000, 0,   0, 'h0000};
        vecs[1] = '{1,1, 1, 'hB, 0,0,0,   0,  0, 0, 0,  'h0000, 0,   0, 'h0000};
        vecs[2] = '{1,1, 2, 'hC, 0,0,0,   0,  0, 0, 0,  'h0000, 0,   0, 'h0000};
        vecs[3] = '{1,1, 3, 'hD, 1,1,0,   0,  1, 1, 0,  'hDCBA, 0,   0, 'h0000};
        vecs[4] = '{1,0, 0, 0,   1,1,0,   1,  1, 0, 4,  'hDCBA, 0,   0, 'h0000};
        vecs[5] = '{1,0, 0, 0,   1,0,0,   1,  1, 0, 0,  'hDCBA, 0,   0, 'h0000};
        vecs[6] = '{1,0, 0, 0,   0,0,0,   0,  0, 0, 0,  'hDCBA, 0,   1, 'h0000};
        vecs[7] = '{1,1, 5, 7,   0,0,0,   0,  0, 0, 0,  'hDCBA, 1,   1, 'hDCBA};
        vecs[8] = '{1,1, 4, 1,   0,0,0,   0,  0, 0, 0,  'hDCBA, 1,   0, 'hDCBA};
        for (int i = 0; i < 9; i++) begin
            step(1, vecs[i].a, 0, vecs[i].v, vecs[i].seg, vecs[i].surv,
                 vecs[i].q, vecs[i].tp, vecs[i].tw);
            $display("vec %0d: gnt=%0b en=%0b we=%0b addr=%0d wdata=%h tbv=%0b tbd=%h",
                     i, seen_gnt, ram_en, ram_we, ram_addr, ram_wdata, tb_valid, tb_data);
            chk("vec_gnt", seen_gnt, 32'(vecs[i].e_gnt));
            chk("vec_en", ram_en, 32'(vecs[i].e_en));
            if (vecs[i].e_en) chk("vec_we", ram_we, 32'(vecs[i].e_we));
            chk("vec_addr", ram_addr, 32'(vecs[i].e_addr));
            chk("vec_wdata", ram_wdata, 32'(vecs[i].e_wdata));
            chk("vec_err_order", err_order, 32'(vecs[i].e_erro));
            chk("vec_tb_valid", tb_valid, 32'(vecs[i].e_tbv));
            chk("vec_tb_data", tb_data, 32'(vecs[i].e_tbd));
        end
        chk("collision_flag", err_rd_collision, 32'd1);

        // Idle write side, read page 0 word 2 of the preloaded RAM
        step(1, 0, 0, 0, 0, 0, 1, 0, 2);
        chk("t3_gnt", seen_gnt, 32'd1);
        chk("t3_cmd_addr", ram_addr, 32'd2);
        chk("t3_cmd_read", {ram_en, ram_we}, 32'b10);
        idle(2);
        chk("t3_valid", tb_valid, 32'd1);
        chk("t3_data", tb_data, 32'(pre2));
        $display("read p0w2: data=%h", tb_data);

        // Finish stage 0 and run eight more stages to wrap the page ring
        for (int i = 0; i < 11 + 8 * 16; i++) step(1, 1, 0, 1, m_exp, int'($urandom_range(0, 15)), 0, 0, 0);
        $display("after wrap: wr_page=%0d writes=%0d", wr_page, wcount);

        // Hold blocks acceptance and grants but not an in-flight read
        step(1, 1, 0, 0, 0, 0, 1, 5, 3);
        step(1, 1, 1, 1, m_exp, 5, 1, 2, 0);
        chk("hold_ready", seen_ready, 32'd0);
        chk("hold_gnt", seen_gnt, 32'd0);
        step(1, 1, 1, 1, m_exp, 5, 1, 2, 0);
        chk("hold_inflight_valid", tb_valid, 32'd1);
        $display("hold: ready=%0b gnt=%0b tb_valid=%0b", seen_ready, seen_gnt, tb_valid);

        // Reset after two beats with a read in flight
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 9, 0, 0, 0);
        step(1, 1, 0, 1, 1, 9, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 3, 1);
        step(0, 1, 0, 1, 2, 9, 1, 3, 1);
        chk("rst_ready", seen_ready, 32'd0);
        chk("rst_gnt", seen_gnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("rst_no_valid", tb_valid, 32'd0);
        end
        for (int s = 0; s < 4; s++) step(1, 1, 0, 1, s, s + 1, 0, 0, 0);
        chk("rst_fresh_we", ram_we, 32'd1);
        chk("rst_fresh_addr", ram_addr, 32'd0);
        chk("rst_fresh_wdata", ram_wdata, 32'h4321);
        $display("post-reset word: addr=%0d wdata=%h", ram_addr, ram_wdata);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r = ($urandom_range(0, 499) != 0);
            int sg = ($urandom_range(0, 9) != 0) ? m_exp : int'($urandom_range(0, 15));
            step(r, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                 sg, int'($urandom_range(0, 15)), $urandom_range(0, 9) < 3,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
